// File: rtl/dunc16_sequencer_if.sv
// -----------------------------------------------------------------------------
// dunc16_sequencer_if
// Groups the control/handshake signals between the instruction sequencer and
// its surroundings (front panel, decoder, memory, datapath).
//
//   master : drives commands, decoded instruction bits and the memory ack;
//            observes the phase strobes, status and instruction count.
//   slave  : the sequencer itself.
//
//   start, step, stop   run control pulses
//   i_sta, i_hlt        decoded store / halt, valid during the execute phase
//   mem_ready           memory acknowledge for a fetch or a write
//   t0, t1              fetch / execute phase strobes
//   execute             one-cycle execute enable to the datapath
//   setwrite, clrwrite  one-cycle pulses that raise / drop the memory write
//   running             high while an instruction is in progress
//   err                 sticky memory-timeout flag
//   instr_cnt           count of completed instructions (wraps)
// -----------------------------------------------------------------------------
interface dunc16_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             step;
    logic             stop;
    logic             i_sta;
    logic             i_hlt;
    logic             mem_ready;
    logic             t0;
    logic             t1;
    logic             execute;
    logic             setwrite;
    logic             clrwrite;
    logic             running;
    logic             err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output start, step, stop, i_sta, i_hlt, mem_ready,
        input  t0, t1, execute, setwrite, clrwrite, running, err, instr_cnt
    );

    modport slave (
        input  start, step, stop, i_sta, i_hlt, mem_ready,
        output t0, t1, execute, setwrite, clrwrite, running, err, instr_cnt
    );
endinterface

// File: rtl/dunc16_sequencer.sv
// -----------------------------------------------------------------------------
// dunc16_sequencer
// Instruction sequencer: walks each instruction through fetch, execute and an
// optional memory-write handshake, supports continuous run, single step and a
// halt request honoured at the next instruction boundary, and traps to an
// error state when memory fails to acknowledge within TIMEOUT wait cycles.
//
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high; overrides every other input
//   bus    : dunc16_sequencer_if.slave (see interface file for signal list)
//
// All outputs are registered Moore outputs decoded from the next state, so
// they are glitch-free and reflect the state the FSM is in this cycle.
// -----------------------------------------------------------------------------
module dunc16_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    dunc16_sequencer_if.slave bus
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        HALTED,
        FETCH,
        EXEC,
        WSET,
        WWAIT,
        WCLR,
        ERROR
    } state_t;

    state_t             state, state_nxt;
    logic               mode_step, mode_step_nxt;      // 1: halt after this instruction
    logic               stop_pending, stop_pending_nxt;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [CNT_W-1:0]   instr_cnt, instr_cnt_nxt;
    logic               boundary;
    logic               running_now;
    logic               last_wait;

    logic t0_q, t1_q, setwrite_q, clrwrite_q, running_q, err_q;

    assign running_now = (state != HALTED) && (state != ERROR);
    // The current cycle is the last permitted wait cycle.
    assign last_wait   = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_nxt        = state;
        mode_step_nxt    = mode_step;
        stop_pending_nxt = stop_pending;
        wait_cnt_nxt     = '0;
        instr_cnt_nxt    = instr_cnt;
        boundary         = 1'b0;

        if (running_now && bus.stop) begin
            stop_pending_nxt = 1'b1;
        end

        case (state)
            HALTED: begin
                // STOP in the same cycle as a launch keeps the machine parked.
                if (!bus.stop) begin
                    if (bus.start) begin
                        state_nxt     = FETCH;
                        mode_step_nxt = 1'b0;
                    end else if (bus.step) begin
                        state_nxt     = FETCH;
                        mode_step_nxt = 1'b1;
                    end
                end
            end
            FETCH, WWAIT: begin
                // Ready is checked before the limit, so an ack on the last
                // permitted wait cycle still succeeds.
                if (bus.mem_ready) begin
                    state_nxt = (state == FETCH) ? EXEC : WCLR;
                end else if (last_wait) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            EXEC: begin
                if (bus.i_hlt) begin
                    state_nxt        = HALTED;
                    instr_cnt_nxt    = instr_cnt + 1'b1;
                    stop_pending_nxt = 1'b0;
                end else if (bus.i_sta) begin
                    state_nxt = WSET;
                end else begin
                    boundary = 1'b1;
                end
            end
            WSET:  state_nxt = WWAIT;
            WCLR:  boundary  = 1'b1;
            ERROR: begin
                if (bus.start) begin
                    state_nxt     = FETCH;
                    mode_step_nxt = 1'b0;
                end else if (bus.step) begin
                    state_nxt     = FETCH;
                    mode_step_nxt = 1'b1;
                end
            end
            default: state_nxt = HALTED;
        endcase

        // Instruction boundary: a STOP arriving in this very cycle also counts.
        if (boundary) begin
            instr_cnt_nxt = instr_cnt + 1'b1;
            if (mode_step || stop_pending || bus.stop) begin
                state_nxt        = HALTED;
                stop_pending_nxt = 1'b0;
            end else begin
                state_nxt = FETCH;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= HALTED;
            mode_step    <= 1'b0;
            stop_pending <= 1'b0;
            wait_cnt     <= '0;
            instr_cnt    <= '0;
            t0_q         <= 1'b0;
            t1_q         <= 1'b0;
            setwrite_q   <= 1'b0;
            clrwrite_q   <= 1'b0;
            running_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_step    <= mode_step_nxt;
            stop_pending <= stop_pending_nxt;
            wait_cnt     <= wait_cnt_nxt;
            instr_cnt    <= instr_cnt_nxt;
            t0_q         <= (state_nxt == FETCH);
            t1_q         <= (state_nxt == EXEC);
            setwrite_q   <= (state_nxt == WSET);
            clrwrite_q   <= (state_nxt == WCLR);
            running_q    <= (state_nxt != HALTED) && (state_nxt != ERROR);
            err_q        <= (state_nxt == ERROR);
        end
    end

    assign bus.t0        = t0_q;
    assign bus.t1        = t1_q;
    assign bus.execute   = t1_q;
    assign bus.setwrite  = setwrite_q;
    assign bus.clrwrite  = clrwrite_q;
    assign bus.running   = running_q;
    assign bus.err       = err_q;
    assign bus.instr_cnt = instr_cnt;
endmodule

// File: tb/tb_dunc16_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dunc16_sequencer
// Self-checking bench for dunc16_sequencer. Two instances share the stimulus:
// one with the default 16-bit counter and one with a 4-bit counter to exercise
// wrap-around. Expected behaviour is modelled per instruction: given the fetch
// latency, store/halt flags, write latency and where a STOP lands, the bench
// knows the exact phase sequence and whether the machine halts afterwards.
// -----------------------------------------------------------------------------
module tb_dunc16_sequencer;
    localparam int TIMEOUT = 15;

    // {t0, t1, setwrite, clrwrite, running, err}
    localparam logic [5:0] S_HALT  = 6'b000000;
    localparam logic [5:0] S_FETCH = 6'b100010;
    localparam logic [5:0] S_EXEC  = 6'b010010;
    localparam logic [5:0] S_SET   = 6'b001010;
    localparam logic [5:0] S_WAIT  = 6'b000010;
    localparam logic [5:0] S_CLR   = 6'b000110;
    localparam logic [5:0] S_ERR   = 6'b000001;

    logic clk = 1'b0;
    logic reset;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_cnt   = 0;
    bit step_mode = 1'b0;

    dunc16_sequencer_if #(.CNT_W(16)) bus  ();
    dunc16_sequencer_if #(.CNT_W(4))  bus4 ();

    assign bus4.start     = bus.start;
    assign bus4.step      = bus.step;
    assign bus4.stop      = bus.stop;
    assign bus4.i_sta     = bus.i_sta;
    assign bus4.i_hlt     = bus.i_hlt;
    assign bus4.mem_ready = bus.mem_ready;

    dunc16_sequencer #(.CNT_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    dunc16_sequencer #(.CNT_W(4), .TIMEOUT(TIMEOUT)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] obs();
        return {bus.t0, bus.t1, bus.setwrite, bus.clrwrite, bus.running, bus.err};
    endfunction

    function automatic logic [5:0] obs4();
        return {bus4.t0, bus4.t1, bus4.setwrite, bus4.clrwrite, bus4.running, bus4.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.step      = 1'b0;
        bus.stop      = 1'b0;
        bus.i_sta     = 1'b0;
        bus.i_hlt     = 1'b0;
        bus.mem_ready = 1'b0;
    endtask

    // Inputs that must have no effect while an instruction is in flight.
    task automatic junk_inputs();
        bus.start     = ($urandom_range(0, 5) == 0);
        bus.step      = ($urandom_range(0, 5) == 0);
        bus.stop      = 1'b0;
        bus.i_sta     = $urandom_range(0, 1) != 0;
        bus.i_hlt     = $urandom_range(0, 1) != 0;
        bus.mem_ready = $urandom_range(0, 1) != 0;
    endtask

    task automatic launch(input bit as_step);
        idle_inputs();
        if (as_step) bus.step = 1'b1;
        else         bus.start = 1'b1;
        bus.mem_ready = $urandom_range(0, 1) != 0;
        tick();
        step_mode = as_step;
        n_checks++;
        if (obs() !== S_FETCH) begin
            n_errors++;
            $display("FAIL launch: got %b want %b", obs(), S_FETCH);
        end
    endtask

    // Runs one instruction from its first FETCH cycle through the boundary.
    // lat_f/lat_w: wait cycles before the ack; stop_at: cycle index of a STOP
    // pulse within the instruction (-1 for none).
    task automatic run_instr(input int lat_f, input bit sta, input bit hlt,
                             input int lat_w, input int stop_at, output bit halted);
        int k;
        bit stop_seen;
        logic [5:0] want;
        k = 0;
        stop_seen = 1'b0;
        for (int i = 0; i <= lat_f; i++) begin
            n_checks++;
            if (obs() !== S_FETCH) begin
                n_errors++;
                $display("FAIL fetch[%0d]: got %b want %b", i, obs(), S_FETCH);
            end
            junk_inputs();
            bus.mem_ready = (i == lat_f);
            bus.stop = (k == stop_at);
            stop_seen = stop_seen | bus.stop;
            k++;
            tick();
        end
        n_checks++;
        if ({obs(), bus.execute} !== {S_EXEC, 1'b1}) begin
            n_errors++;
            $display("FAIL exec: got %b want %b", {obs(), bus.execute}, {S_EXEC, 1'b1});
        end
        junk_inputs();
        bus.i_sta = sta;
        bus.i_hlt = hlt;
        bus.stop = (k == stop_at);
        stop_seen = stop_seen | bus.stop;
        k++;
        tick();
        if (sta && !hlt) begin
            n_checks++;
            if (obs() !== S_SET) begin
                n_errors++;
                $display("FAIL wset: got %b want %b", obs(), S_SET);
            end
            junk_inputs();
            bus.stop = (k == stop_at);
            stop_seen = stop_seen | bus.stop;
            k++;
            tick();
            for (int j = 0; j <= lat_w; j++) begin
                n_checks++;
                if (obs() !== S_WAIT) begin
                    n_errors++;
                    $display("FAIL wwait[%0d]: got %b want %b", j, obs(), S_WAIT);
                end
                junk_inputs();
                bus.mem_ready = (j == lat_w);
                bus.stop = (k == stop_at);
                stop_seen = stop_seen | bus.stop;
                k++;
                tick();
            end
            n_checks++;
            if (obs() !== S_CLR) begin
                n_errors++;
                $display("FAIL wclr: got %b want %b", obs(), S_CLR);
            end
            junk_inputs();
            bus.stop = (k == stop_at);
            stop_seen = stop_seen | bus.stop;
            k++;
            tick();
        end
        exp_cnt++;
        halted = hlt || step_mode || stop_seen;
        want = halted ? S_HALT : S_FETCH;
        n_checks++;
        if (obs() !== want || obs4() !== want) begin
            n_errors++;
            $display("FAIL boundary: got %b/%b want %b", obs(), obs4(), want);
        end
        n_checks++;
        if (bus.instr_cnt !== exp_cnt[15:0] || bus4.instr_cnt !== exp_cnt[3:0]) begin
            n_errors++;
            $display("FAIL instr_cnt: got %0d/%0d want %0d/%0d", bus.instr_cnt,
                     bus4.instr_cnt, exp_cnt[15:0], exp_cnt[3:0]);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        junk_inputs();
        tick();
        tick();
        n_checks++;
        if ({obs(), bus.execute, bus.instr_cnt} !== {S_HALT, 1'b0, 16'd0} ||
            {obs4(), bus4.instr_cnt} !== {S_HALT, 4'd0}) begin
            n_errors++;
            $display("FAIL reset: got %b %b cnt %0d want all zero", obs(), bus.execute, bus.instr_cnt);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
        exp_cnt = 0;
        n_checks++;
        if (obs() !== S_HALT) begin
            n_errors++;
            $display("FAIL post_reset: got %b want %b", obs(), S_HALT);
        end
    endtask

    task automatic test_halted_inputs();
        logic [5:0] stim [4] = '{6'b001000, 6'b101000, 6'b011000, 6'b000111};
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            {bus.start, bus.step, bus.stop, bus.i_sta, bus.i_hlt, bus.mem_ready} = stim[c];
            tick();
            n_checks++;
            if (obs() !== S_HALT || bus.instr_cnt !== exp_cnt[15:0]) begin
                n_errors++;
                $display("FAIL halted_in[%0d]: got %b cnt %0d want %b cnt %0d", c, obs(),
                         bus.instr_cnt, S_HALT, exp_cnt[15:0]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_run_continuous();
        bit h;
        launch(1'b0);
        for (int n = 0; n < 5; n++) run_instr(0, 1'b0, 1'b0, 0, -1, h);
        n_checks++;
        if (bus.instr_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL run_cnt5: got %0d want 5", bus.instr_cnt);
        end
        // STOP during FETCH: the instruction completes, then the machine parks.
        run_instr(0, 1'b0, 1'b0, 0, 0, h);
        for (int n = 0; n < 3; n++) begin
            tick();
            n_checks++;
            if (obs() !== S_HALT) begin
                n_errors++;
                $display("FAIL stop_parked[%0d]: got %b want %b", n, obs(), S_HALT);
            end
        end
    endtask

    task automatic test_step_store();
        bit h;
        launch(1'b1);
        run_instr(0, 1'b1, 1'b0, 2, -1, h);
    endtask

    task automatic test_halt_instr();
        bit h;
        launch(1'b0);
        run_instr(1, 1'b1, 1'b1, 0, -1, h);
    endtask

    task automatic test_timeout_fetch();
        bit h;
        int cnt_before;
        cnt_before = exp_cnt;
        launch(1'b0);
        for (int i = 0; i < TIMEOUT; i++) begin
            n_checks++;
            if (obs() !== S_FETCH) begin
                n_errors++;
                $display("FAIL to_fetch[%0d]: got %b want %b", i, obs(), S_FETCH);
            end
            junk_inputs();
            bus.mem_ready = 1'b0;
            bus.start = 1'b0;
            tick();
        end
        n_checks++;
        if (obs() !== S_ERR) begin
            n_errors++;
            $display("FAIL to_error: got %b want %b", obs(), S_ERR);
        end
        idle_inputs();
        bus.stop = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        n_checks++;
        if (obs() !== S_ERR || bus.instr_cnt !== cnt_before[15:0]) begin
            n_errors++;
            $display("FAIL err_sticky: got %b cnt %0d want %b cnt %0d", obs(), bus.instr_cnt,
                     S_ERR, cnt_before[15:0]);
        end
        launch(1'b0);
        run_instr(TIMEOUT - 1, 1'b0, 1'b0, 0, 0, h);
    endtask

    task automatic test_timeout_wwait();
        bit h;
        launch(1'b1);
        idle_inputs();
        bus.mem_ready = 1'b1;
        tick();
        idle_inputs();
        bus.i_sta = 1'b1;
        tick();
        idle_inputs();
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            n_checks++;
            if (obs() !== S_WAIT) begin
                n_errors++;
                $display("FAIL to_wwait[%0d]: got %b want %b", i, obs(), S_WAIT);
            end
            idle_inputs();
            tick();
        end
        n_checks++;
        if (obs() !== S_ERR || bus.instr_cnt !== exp_cnt[15:0]) begin
            n_errors++;
            $display("FAIL wwait_error: got %b cnt %0d want %b cnt %0d", obs(), bus.instr_cnt,
                     S_ERR, exp_cnt[15:0]);
        end
        launch(1'b1);
        run_instr(0, 1'b1, 1'b0, TIMEOUT - 1, -1, h);
    endtask

    task automatic test_reset_midwrite();
        launch(1'b0);
        idle_inputs();
        bus.mem_ready = 1'b1;
        tick();
        idle_inputs();
        bus.i_sta = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        n_checks++;
        if ({obs(), bus.execute, bus.instr_cnt} !== {S_HALT, 1'b0, 16'd0}) begin
            n_errors++;
            $display("FAIL reset_wwait: got %b %b cnt %0d want all zero", obs(), bus.execute,
                     bus.instr_cnt);
        end
        idle_inputs();
        tick();
        n_checks++;
        if (obs() !== S_HALT) begin
            n_errors++;
            $display("FAIL reset_no_clr: got %b want %b", obs(), S_HALT);
        end
    endtask

    task automatic test_wrap();
        bit h;
        launch(1'b0);
        for (int n = 0; n < 17; n++) run_instr(0, 1'b0, 1'b0, 0, (n == 16) ? 0 : -1, h);
        n_checks++;
        if (bus4.instr_cnt !== 4'd1 || bus.instr_cnt !== 16'd17) begin
            n_errors++;
            $display("FAIL wrap: got %0d/%0d want 1/17", bus4.instr_cnt, bus.instr_cnt);
        end
    endtask

    task automatic test_random();
        bit h;
        bit is_sta;
        bit is_hlt;
        int lat_f;
        int lat_w;
        int stop_at;
        h = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (h) launch($urandom_range(0, 1) != 0);
            lat_f   = $urandom_range(0, TIMEOUT - 1);
            lat_w   = $urandom_range(0, TIMEOUT - 1);
            is_sta  = $urandom_range(0, 1) != 0;
            is_hlt  = ($urandom_range(0, 7) == 0);
            stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat_f + 3) : -1;
            run_instr(lat_f, is_sta, is_hlt, lat_w, stop_at, h);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_halted_inputs();
        test_run_continuous();
        test_step_store();
        test_halt_instr();
        test_timeout_fetch();
        test_timeout_wwait();
        test_reset_midwrite();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dunc16_sequencer.md
DUNC16_SEQUENCER -- requirements
Module: dunc16_sequencer

Interface
REQ-001 Parameter CNT_W, default 16: width of the instruction counter.
REQ-002 Parameter TIMEOUT, default 15: maximum number of wait cycles for MEM_READY before an error is flagged.
REQ-003 CLK  in  1  sole clock; all logic is clocked on the rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 START  in  1  begin continuous run (single-cycle pulse).
REQ-006 STEP  in  1  run exactly one instruction (single-cycle pulse).
REQ-007 STOP  in  1  request halt at the next instruction boundary (single-cycle pulse).
REQ-008 I_STA  in  1  decoded store instruction; valid in EXEC.
REQ-009 I_HLT  in  1  decoded halt instruction; valid in EXEC.
REQ-010 MEM_READY  in  1  memory acknowledge for a fetch or write.
REQ-011 T0  out  1  fetch phase strobe.
REQ-012 T1  out  1  execute phase strobe.
REQ-013 EXECUTE  out  1  one-cycle execute enable to the datapath.
REQ-014 SETWRITE  out  1  one-cycle pulse that asserts the memory write.
REQ-015 CLRWRITE  out  1  one-cycle pulse that deasserts the memory write.
REQ-016 RUNNING  out  1  high in every state except HALTED and ERROR.
REQ-017 ERR  out  1  sticky memory-timeout flag.
REQ-018 INSTR_CNT  out  CNT_W  count of completed instructions.

Function
REQ-019 The FSM SHALL have the states HALTED, FETCH, EXEC, WSET, WWAIT, WCLR, ERROR, and SHALL implement them as registered Moore outputs.
REQ-020 HALTED: all strobes SHALL be 0.
- START -> FETCH with mode=run.
- STEP -> FETCH with mode=step.
- STOP in the same cycle as START or STEP SHALL win: the FSM stays in HALTED.
REQ-021 FETCH: T0=1 for every cycle in the state.
- MEM_READY=1 -> EXEC.
- Otherwise the wait counter increments; on reaching TIMEOUT wait cycles -> ERROR.
REQ-022 EXEC (exactly 1 cycle): T1=1 and EXEC=1.
- I_HLT=1 -> HALTED; I_HLT has priority over I_STA.
- I_STA=1 -> WSET.
- Otherwise the FSM takes the boundary decision (REQ-025).
REQ-023 WSET: SETWRITE=1 for 1 cycle, then -> WWAIT.
- WWAIT: MEM_READY=1 -> WCLR; the same TIMEOUT rule as FETCH applies (-> ERROR).
REQ-024 WCLR: CLRWRITE=1 for 1 cycle, then the boundary decision (REQ-025).
REQ-025 Boundary decision, taken at the end of EXEC without a store or at the end of WCLR:
- INSTR_CNT increments by 1 and wraps modulo 2^CNT_W.
- If mode=step or stop_pending=1 -> HALTED and clear stop_pending; else -> FETCH.
- An instruction terminated by I_HLT SHALL also increment INSTR_CNT.
REQ-026 STOP SHALL set stop_pending in any RUNNING state, and SHALL be ignored in HALTED and ERROR.
REQ-027 START and STEP SHALL be ignored while RUNNING=1.
REQ-028 MEM_READY SHALL be ignored outside FETCH and WWAIT.
REQ-029 The wait counter SHALL clear on entry to FETCH and to WWAIT.
- A wait of exactly TIMEOUT-1 cycles followed by MEM_READY SHALL succeed.
REQ-030 ERROR: ERR=1 and all strobes 0.
- START -> FETCH with mode=run and clears ERR.
- STEP -> FETCH with mode=step and clears ERR.
- STOP has no effect in ERROR.
REQ-031 At most one of T0, T1, SETWRITE, CLRWRITE SHALL be high in any cycle.
REQ-032 A SETWRITE pulse SHALL always be followed by a CLRWRITE pulse unless RESET intervenes.

Reset
REQ-033 While RESET=1, the next edge SHALL force:
- state=HALTED, mode=run, stop_pending=0;
- wait counter=0, INSTR_CNT=0, ERR=0;
- all outputs 0.
REQ-034 RESET SHALL override every other input in the same cycle, including mid-write (WWAIT): no CLRWRITE pulse is issued.

Verification
REQ-035 Reset, then START, with MEM_READY=1 always and I_STA=I_HLT=0 -> T0 and T1 alternate with period 2; INSTR_CNT=5 after 10 cycles of running.
REQ-036 STEP with I_STA=1 in EXEC and MEM_READY raised 3 cycles after SETWRITE:
- sequence T0, T1, SETWRITE, 3 wait cycles, CLRWRITE, then HALTED;
- INSTR_CNT=1.
REQ-037 STOP pulsed during FETCH while running -> the current instruction completes, then HALTED, RUNNING=0, and no further T0 is issued.
REQ-038 MEM_READY held 0 in FETCH -> ERR=1 and the FSM enters ERROR after TIMEOUT=15 wait cycles; a subsequent START clears ERR and T0 reasserts.
REQ-039 RESET asserted in WWAIT -> next cycle all outputs 0, state HALTED, INSTR_CNT=0, and no CLRWRITE is issued.
REQ-040 With CNT_W=4, run 17 instructions -> INSTR_CNT=1 (wrap).
